// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller with latched car/hall calls and timed travel and door dwell.
// Decisions use the registered latches, so a call pulse leaves IDLE two cycles after it is sampled.
module elevator_scan_ctrl #(
    parameter int FLOORS        = 8,
    parameter int FLOOR_W       = $clog2(FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [FLOORS-1:0]  car_call,
    input  logic [FLOORS-1:0]  hall_up,
    input  logic [FLOORS-1:0]  hall_down,
    input  logic               door_hold,
    output logic [FLOOR_W-1:0] floor_number,
    output logic               dir,
    output logic               moving,
    output logic               door_open,
    output logic               arrive,
    output logic [FLOORS-1:0]  pending
);

    localparam int TW = $clog2(TRAVEL_CYCLES + 1);
    localparam int DW = $clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0]     TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]     DOOR_LAST   = DW'(DOOR_CYCLES - 1);
    localparam logic [FLOORS-1:0] UP_OK       = ~(FLOORS'(1) << (FLOORS - 1));
    localparam logic [FLOORS-1:0] DN_OK       = ~FLOORS'(1);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;

    state_t             state, state_n;
    logic [FLOOR_W-1:0] floor_n, next_floor, serve_floor;
    logic               dir_n, arrive_n, serve, hall_here, hall_opp, restart;
    logic [TW-1:0]      travel_cnt, travel_n;
    logic [DW-1:0]      door_cnt, door_n;
    logic [FLOORS-1:0]  car_q, up_q, dn_q, all_q;
    logic [FLOORS-1:0]  car_set, up_set, dn_set;
    logic [FLOORS-1:0]  car_clr, up_clr, dn_clr;
    logic [FLOORS-1:0]  car_n, up_n, dn_n;

    // True when any request lies strictly past floor f in direction up.
    function automatic logic beyond(input logic [FLOORS-1:0] req,
                                    input logic [FLOOR_W-1:0] f,
                                    input logic up);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (up ? (i > int'(f)) : (i < int'(f))) r = r | req[i];
        end
        return r;
    endfunction

    assign moving    = (state == MOVE);
    assign door_open = (state == DOOR);

    always_comb begin
        all_q       = car_q | up_q | dn_q;
        state_n     = state;
        floor_n     = floor_number;
        dir_n       = dir;
        travel_n    = travel_cnt;
        door_n      = door_cnt;
        arrive_n    = 1'b0;
        serve       = 1'b0;
        serve_floor = floor_number;
        restart     = 1'b0;
        next_floor  = dir ? floor_number + FLOOR_W'(1) : floor_number - FLOOR_W'(1);
        hall_here   = dir ? up_q[next_floor] : dn_q[next_floor];
        hall_opp    = dir ? dn_q[next_floor] : up_q[next_floor];
        car_set     = car_call;
        up_set      = hall_up & UP_OK;
        dn_set      = hall_down & DN_OK;
        car_clr     = '0;
        up_clr      = '0;
        dn_clr      = '0;

        case (state)
            IDLE: begin
                if (all_q[floor_number]) begin
                    if (!car_q[floor_number] && !(dir ? up_q[floor_number] : dn_q[floor_number]))
                        dir_n = ~dir;
                    state_n = DOOR;
                    door_n  = '0;
                    serve   = 1'b1;
                end else if (dir && beyond(all_q, floor_number, 1'b1)) begin
                    state_n  = MOVE;
                    travel_n = '0;
                end else if (!dir && beyond(all_q, floor_number, 1'b0)) begin
                    state_n  = MOVE;
                    travel_n = '0;
                end else if (|all_q) begin
                    dir_n = ~dir;
                end
            end
            MOVE: begin
                if (travel_cnt == TRAVEL_LAST) begin
                    travel_n = '0;
                    floor_n  = next_floor;
                    arrive_n = 1'b1;
                    if (car_q[next_floor] || hall_here || !beyond(all_q, next_floor, dir)) begin
                        // End of sweep with only the opposite hall call here: turn around.
                        if (!car_q[next_floor] && !hall_here && hall_opp)
                            dir_n = ~dir;
                        state_n     = DOOR;
                        door_n      = '0;
                        serve       = 1'b1;
                        serve_floor = next_floor;
                    end
                end else begin
                    travel_n = travel_cnt + TW'(1);
                end
            end
            DOOR: begin
                // Same-direction calls at an open door are absorbed, not latched.
                restart = car_set[floor_number] ||
                          (dir ? up_set[floor_number] : dn_set[floor_number]);
                car_set[floor_number] = 1'b0;
                if (dir) up_set[floor_number] = 1'b0;
                else     dn_set[floor_number] = 1'b0;
                if (door_hold || restart) begin
                    door_n = '0;
                end else if (door_cnt == DOOR_LAST) begin
                    state_n = IDLE;
                    door_n  = '0;
                end else begin
                    door_n = door_cnt + DW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (serve) begin
            car_clr = FLOORS'(1) << serve_floor;
            if (dir_n) up_clr = FLOORS'(1) << serve_floor;
            else       dn_clr = FLOORS'(1) << serve_floor;
        end

        // Clears are only raised on DOOR entry, where they must beat a same-cycle set.
        car_n = (car_q | car_set) & ~car_clr;
        up_n  = (up_q  | up_set)  & ~up_clr;
        dn_n  = (dn_q  | dn_set)  & ~dn_clr;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            floor_number <= '0;
            dir          <= 1'b1;
            travel_cnt   <= '0;
            door_cnt     <= '0;
            arrive       <= 1'b0;
            car_q        <= '0;
            up_q         <= '0;
            dn_q         <= '0;
            pending      <= '0;
        end else begin
            state        <= state_n;
            floor_number <= floor_n;
            dir          <= dir_n;
            travel_cnt   <= travel_n;
            door_cnt     <= door_n;
            arrive       <= arrive_n;
            car_q        <= car_n;
            up_q         <= up_n;
            dn_q         <= dn_n;
            pending      <= car_n | up_n | dn_n;
        end
    end

endmodule
